// File: rtl/encoder_8to3_seq.sv
`default_nettype none
// ============================================================================
// Module      : encoder_8to3_seq
// Description : Sequential 8-to-3 priority encoder. It captures event requests
//               into a pending register and drains them as 3-bit codes over a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_8to3_seq #(
    parameter int N_IN     = 8,
    parameter bit LSB_PRIO = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N_IN-1:0] req,
    input  logic            ready,
    input  logic            clr_ovf,
    output logic [2:0]      code,
    output logic            valid,
    output logic [N_IN-1:0] pend,
    output logic [3:0]      pend_cnt,
    output logic            ovf
);

    localparam int              c_CODE_W  = 3;
    localparam logic [N_IN-1:0] c_ONE     = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [0:0]      c_ST_IDLE = 1'b0;
    localparam logic [0:0]      c_ST_HOLD = 1'b1;

    logic [0:0]          r_state;
    logic [N_IN-1:0]     r_pend;
    logic [c_CODE_W-1:0] r_code;
    logic                r_valid;
    logic                r_ovf;

    logic                w_xfer;
    logic [N_IN-1:0]     w_clear_mask;
    logic [N_IN-1:0]     w_set_mask;
    logic [N_IN-1:0]     w_pend_next;
    logic [c_CODE_W-1:0] w_prio;
    logic                w_any;
    logic                w_ovf_hit;
    logic [3:0]          w_cnt;

    // Highest-priority set bit; an empty vector encodes as 0.
    function automatic logic [c_CODE_W-1:0] prio_of(input logic [N_IN-1:0] x);
        logic [c_CODE_W-1:0] w_sel;
        w_sel = '0;
        if (LSB_PRIO) begin
            for (int i = N_IN - 1; i >= 0; i--)
                if (x[i]) w_sel = c_CODE_W'(i);
        end else begin
            for (int i = 0; i < N_IN; i++)
                if (x[i]) w_sel = c_CODE_W'(i);
        end
        return w_sel;
    endfunction

    assign w_xfer       = r_valid & ready;
    assign w_clear_mask = w_xfer ? (c_ONE << r_code) : '0;
    assign w_set_mask   = en ? req : '0;
    // Set is OR-ed after the clear so a re-request on the bit being drained survives.
    assign w_pend_next  = (r_pend & ~w_clear_mask) | w_set_mask;
    assign w_prio       = prio_of(w_pend_next);
    assign w_any        = |w_pend_next;
    assign w_ovf_hit    = |(w_set_mask & r_pend & ~w_clear_mask);

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < N_IN; i++)
            w_cnt = w_cnt + {3'b000, r_pend[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_pend  <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            r_ovf  <= w_ovf_hit | (r_ovf & ~clr_ovf);
            case (r_state)
                c_ST_IDLE: begin
                    r_code  <= w_prio;
                    r_valid <= w_any;
                    r_state <= w_any ? c_ST_HOLD : c_ST_IDLE;
                end
                c_ST_HOLD: begin
                    // The presented code is never preempted; it only advances on a transfer.
                    if (w_xfer) begin
                        r_code  <= w_prio;
                        r_valid <= w_any;
                        r_state <= w_any ? c_ST_HOLD : c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign code     = r_code;
    assign valid    = r_valid;
    assign pend     = r_pend;
    assign pend_cnt = w_cnt;
    assign ovf      = r_ovf;

endmodule
`default_nettype wire
